// File: rtl/regfile_mp_if.sv
// Register-file bus: one write port, NUM_RD packed read ports, and sweep status.
// The master side drives requests; the register file sits on the slave side.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic                     clr_busy;
   logic                     wr_drop;

   modport master (
      output wr_en,
      output wr_addr,
      output wr_data,
      output rd_addr,
      input  rd_data,
      input  clr_busy,
      input  wr_drop
   );

   modport slave (
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  rd_addr,
      output rd_data,
      output clr_busy,
      output wr_drop
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a hardware clear sweep.
// After reset a CLEAR sweep writes entries 1..DEPTH-1 (SP_IDX gets SP_INIT, the
// rest zero), one per cycle, then the controller sits in RUN. Entry 0 is a
// hard-wired zero. Reads are registered with a write-first bypass, so every
// output comes straight from a flop.
module regfile_mp #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NUM_RD  = 2,
   parameter int SP_IDX  = 29,
   parameter int SP_INIT = 252
) (
   input  logic        clk,
   input  logic        nrst,   // synchronous, active-high
   regfile_mp_if.slave bus
);

   localparam int                DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] SP_ADDR   = ADDR_W'(SP_IDX);
   localparam logic [DATA_W-1:0] SP_VALUE  = DATA_W'(SP_INIT);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t                   state_q;
   state_t                   state_d;
   logic [ADDR_W-1:0]        idx_q;
   logic [DATA_W-1:0]        mem [DEPTH];
   logic [NUM_RD*DATA_W-1:0] rd_d;
   logic [NUM_RD*DATA_W-1:0] rd_q;
   logic                     drop_q;
   logic                     sweep_wr;
   logic                     user_wr;
   logic                     user_drop;

   // Controller next state plus the per-cycle write/drop decisions.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d   = state_q;
      sweep_wr  = 1'b0;
      user_wr   = 1'b0;
      user_drop = 1'b0;
      if (nrst) begin
         state_d = CLEAR;
      end else begin
         case (state_q)
            CLEAR: begin
               sweep_wr  = 1'b1;
               // Address-0 writes are ignored everywhere, so they never count as dropped.
               user_drop = bus.wr_en && (bus.wr_addr != '0);
               if (idx_q == LAST_IDX) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               user_wr = bus.wr_en && (bus.wr_addr != '0);
            end
            default: begin
               state_d = CLEAR;
            end
         endcase
      end
   end

   // Controller state register; reset is folded into state_d.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= state_d;
   end

   // Sweep index: parked at 1 under reset, walks up to DEPTH-1 during CLEAR.
   always_ff @(posedge clk) begin
      if (nrst) begin
         idx_q <= FIRST_IDX;
      end else if (sweep_wr && (idx_q != LAST_IDX)) begin
         idx_q <= idx_q + 1'b1;
      end
   end

   // Storage array: the sweep owns the write port in CLEAR, the user in RUN.
   always_ff @(posedge clk) begin
      // NOTE: the array is deliberately not reset; the clear sweep initialises it instead.
      if (sweep_wr) begin
         mem[idx_q] <= (idx_q == SP_ADDR) ? SP_VALUE : '0;
      end else if (user_wr) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Read mux per port: zero under reset/CLEAR or for entry 0, bypass on a same-cycle write.
   always_comb begin
      rd_d = '0;
      if (!nrst && (state_q == RUN)) begin
         for (int p = 0; p < NUM_RD; p++) begin
            if (bus.rd_addr[p*ADDR_W +: ADDR_W] == '0) begin
               rd_d[p*DATA_W +: DATA_W] = '0;
            end else if (user_wr && (bus.wr_addr == bus.rd_addr[p*ADDR_W +: ADDR_W])) begin
               rd_d[p*DATA_W +: DATA_W] = bus.wr_data;
            end else begin
               rd_d[p*DATA_W +: DATA_W] = mem[bus.rd_addr[p*ADDR_W +: ADDR_W]];
            end
         end
      end
   end

   // Registered read data and drop flag; both are already zero under reset.
   always_ff @(posedge clk) begin
      rd_q   <= rd_d;
      drop_q <= user_drop;
   end

   assign bus.rd_data  = rd_q;
   assign bus.clr_busy = (state_q == CLEAR);
   assign bus.wr_drop  = drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. Each step drives inputs on the falling edge and
// queues the outputs expected after the next rising edge; a monitor pops one
// entry per cycle just after the rising edge and compares.
module tb_regfile_mp;

   logic clk = 1'b0;
   logic nrst;

   regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

   regfile_mp #(
      .DATA_W (32),
      .ADDR_W (5),
      .NUM_RD (2),
      .SP_IDX (29),
      .SP_INIT(252)
   ) dut (
      .clk (clk),
      .nrst(nrst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d0;
      logic [31:0] d1;
      logic        busy;
      logic        drop;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   // One cycle of stimulus plus the outputs it should produce after the next rise.
   task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic eb, input logic ed, input string name);
      exp_t e;
      @(negedge clk);
      nrst        = rst;
      bus.wr_en   = we;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      bus.rd_addr = {ra1, ra0};
      e.d0   = e0;
      e.d1   = e1;
      e.busy = eb;
      e.drop = ed;
      e.name = name;
      exp_q.push_back(e);
   endtask

   // Monitor: compare DUT outputs against the oldest queued expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({e.name, ".rd0"},     bus.rd_data[31:0],    e.d0);
         check({e.name, ".rd1"},     bus.rd_data[63:32],   e.d1);
         check({e.name, ".clr_busy"}, 32'(bus.clr_busy),   32'(e.busy));
         check({e.name, ".wr_drop"},  32'(bus.wr_drop),    32'(e.drop));
      end
   end

   initial begin
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;

      nrst        = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.rd_addr = '0;

      // Phase A: one-cycle reset pulse, then the full sweep with writes mixed in.
      step(1, 0, 0, 0, 29, 3, 0, 0, 1, 0, "rstA");
      for (int k = 1; k <= 31; k++) begin
         we = (k == 5) || (k == 8);
         wa = (k == 5) ? 5'd3 : 5'd0;
         wd = (k == 5) ? 32'hAAAA_5555 : 32'hFFFF_FFFF;
         // Reads stay 0 in CLEAR; only the addr-3 write at sweep cycle 5 drops.
         step(0, we, wa, wd, 29, 3, 0, 0, (k < 31), (k == 5), $sformatf("sweepA%0d", k));
      end

      // Phase B: RUN behaviour.
      step(0, 0, 0,  0,            29,  5, 32'd252,       0,             0, 0, "sp_read");
      step(0, 0, 0,  0,             3, 31, 0,             0,             0, 0, "cleared_3_31");
      step(0, 0, 0,  0,             1,  0, 0,             0,             0, 0, "idx1_zero");
      step(0, 1, 7,  32'hDEADBEEF,  0,  0, 0,             0,             0, 0, "wr7");
      step(0, 0, 0,  0,             7,  7, 32'hDEADBEEF,  32'hDEADBEEF,  0, 0, "rd7");
      step(0, 1, 9,  32'h12345678,  9,  9, 32'h12345678,  32'h12345678,  0, 0, "bypass9");
      step(0, 0, 0,  0,             9, 29, 32'h12345678,  32'd252,       0, 0, "rd9");
      step(0, 1, 0,  32'hFFFFFFFF,  0,  0, 0,             0,             0, 0, "wr0");
      step(0, 0, 0,  0,             0,  7, 0,             32'hDEADBEEF,  0, 0, "rd0");
      step(0, 1, 29, 32'h00000111,  5, 29, 0,             32'h00000111,  0, 0, "bypass29_p1");
      step(0, 0, 0,  0,            29,  7, 32'h00000111,  32'hDEADBEEF,  0, 0, "rd29");
      step(0, 1, 31, 32'hCAFEF00D, 30, 31, 0,             32'hCAFEF00D,  0, 0, "bypass31");
      step(0, 1, 7,  32'h0BADF00D, 31,  9, 32'hCAFEF00D,  32'h12345678,  0, 0, "wr7b");
      step(0, 0, 0,  0,             7,  7, 32'h0BADF00D,  32'h0BADF00D,  0, 0, "rd7b");

      // Phase C: reset from RUN held two cycles, then reset again mid-sweep.
      step(1, 0, 0, 0, 7, 29, 0, 0, 1, 0, "rst_run");
      step(1, 0, 0, 0, 7, 29, 0, 0, 1, 0, "rst_held");
      for (int k = 1; k <= 9; k++) begin
         we = (k == 8);
         step(0, we, 5'd4, 32'h5555_AAAA, 7, 29, 0, 0, 1, (k == 8), $sformatf("sweepC%0d", k));
      end
      step(1, 0, 0, 0, 7, 29, 0, 0, 1, 0, "rst_mid");
      for (int k = 1; k <= 31; k++) begin
         step(0, 0, 0, 0, 7, 29, 0, 0, (k < 31), 0, $sformatf("sweepD%0d", k));
      end
      step(0, 0, 0, 0, 7, 29, 0, 32'd252, 0, 0, "post_7_29");
      step(0, 0, 0, 0, 9, 31, 0, 0,       0, 0, "post_9_31");
      step(0, 0, 0, 0, 4, 30, 0, 0,       0, 0, "post_4_30");

      // Let the monitor drain the queue, bounded.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(posedge clk);
      end
      #2;
      check("drain_queue", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
